wallace_tree_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 5-input combinational Wallace adder.

---
 rtl/wallace_pkg.sv | 39 +++
 rtl/csa3_2.sv | 19 +
 rtl/wallace_tree_pipe.sv | 118 +++++++++++
 tb/tb_wallace_tree_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Elaboration-time helpers that size the Wallace reduction tree and its pipeline.
// Shared by the top level and anything else that needs the layer/stage geometry.
package wallace_pkg;

    function automatic int wt_next_rows(input int r);
        return (32'sd2 * (r / 32'sd3)) + (r % 32'sd3);
    endfunction

    function automatic int wt_rows(input int n, input int k);
        int r;
        r = n;
        for (int i = 0; i < k; i++) begin
            r = wt_next_rows(r);
        end
        return r;
    endfunction

    // Bounded loop keeps the function a legal constant function for any NUM_IN.
    function automatic int wt_layers(input int n);
        int r;
        int l;
        r = n;
        l = 32'sd0;
        for (int i = 0; i < 64; i++) begin
            if (r > 32'sd2) begin
                r = wt_next_rows(r);
                l = l + 32'sd1;
            end
        end
        return l;
    endfunction

    function automatic int wt_stages(input int n, input int re);
        int l;
        l = wt_layers(n);
        return ((l + re - 32'sd1) / re) + 32'sd1;
    endfunction

endpackage

// File: rtl/csa3_2.sv
// 3:2 carry-save adder row: bitwise sum plus majority carry shifted up one bit.
// The carry out of the MSB is discarded because the tree works modulo 2^WIDTH.
module csa3_2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] maj_s;

    assign sum   = a ^ b ^ c;
    assign maj_s = (a & b) | (a & c) | (b & c);
    assign carry = maj_s << 1'b1;

endmodule

// File: rtl/wallace_tree_pipe.sv
// Pipelined NUM_IN-operand modulo-2^WIDTH adder: CSA reduction layers, a final
// ripple add, and a single global stall enable shared by every stage.
module wallace_tree_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_IN    = 5,
    parameter int REG_EVERY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
);

    localparam int L  = wt_layers(NUM_IN);
    localparam int NS = wt_stages(NUM_IN, REG_EVERY);

    logic              adv_s;
    logic [NS-1:0]     valid_r;
    logic [WIDTH-1:0]  lin_s [0:L][0:NUM_IN-1];
    logic [WIDTH-1:0]  sum_s;
    logic [WIDTH-1:0]  out_data_r;

    // Whole pipeline moves together; only a stalled, occupied output blocks it.
    assign adv_s    = ~valid_r[NS-1] | out_ready;
    assign in_ready = adv_s;

    for (genvar j = 0; j < NUM_IN; j++) begin : g_in
        assign lin_s[0][j] = in_data[j*WIDTH +: WIDTH];
    end

    for (genvar k = 0; k < L; k++) begin : g_layer
        localparam int  RIN      = wt_rows(NUM_IN, k);
        localparam int  ROUT     = wt_rows(NUM_IN, k + 1);
        localparam int  NGRP     = RIN / 3;
        localparam bit  REG_HERE = (((k + 1) % REG_EVERY) == 0) || (k == L - 1);

        logic [WIDTH-1:0] row_s [0:NUM_IN-1];

        for (genvar g = 0; g < NGRP; g++) begin : g_csa
            csa3_2 #(
                .WIDTH (WIDTH)
            ) u_csa (
                .a     (lin_s[k][3*g]),
                .b     (lin_s[k][3*g+1]),
                .c     (lin_s[k][3*g+2]),
                .sum   (row_s[2*g]),
                .carry (row_s[2*g+1])
            );
        end

        // Leftover rows follow the S/C pairs unchanged.
        for (genvar p = 0; p < RIN - 3*NGRP; p++) begin : g_pass
            assign row_s[2*NGRP+p] = lin_s[k][3*NGRP+p];
        end

        for (genvar j = ROUT; j < NUM_IN; j++) begin : g_zero
            assign row_s[j] = {WIDTH{1'b0}};
        end

        if (REG_HERE) begin : g_reg
            logic [WIDTH-1:0] row_r [0:NUM_IN-1];

            // Stage data register: loads on advance, content ignored when its valid is low.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < NUM_IN; j++) begin
                        row_r[j] <= {WIDTH{1'b0}};
                    end
                end else if (adv_s) begin
                    for (int j = 0; j < NUM_IN; j++) begin
                        row_r[j] <= row_s[j];
                    end
                end
            end

            for (genvar j = 0; j < NUM_IN; j++) begin : g_out
                assign lin_s[k+1][j] = row_r[j];
            end
        end else begin : g_comb
            for (genvar j = 0; j < NUM_IN; j++) begin : g_out
                assign lin_s[k+1][j] = row_s[j];
            end
        end
    end

    assign sum_s = lin_s[L][0] + lin_s[L][1];

    // Final stage holds the ripple-add result so the output is glitch-free and stall-stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data_r <= {WIDTH{1'b0}};
        end else if (adv_s) begin
            out_data_r <= sum_s;
        end
    end

    // Valid shift register; flush empties it regardless of stall, bubbles are kept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= {NS{1'b0}};
        end else if (flush) begin
            valid_r <= {NS{1'b0}};
        end else if (adv_s) begin
            valid_r <= NS'({valid_r, in_valid & adv_s});
        end
    end

    assign out_valid = valid_r[NS-1];
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_wallace_tree_pipe.sv
// Self-checking bench: constant vector table, random backpressure stream against a
// queue scoreboard, flush/reset sequences, and a parameter sweep of extra instances.
module tb_wallace_tree_pipe;

    localparam int W = 16;
    localparam int N = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_main = 1'b1;
    logic           rst_sw   = 1'b1;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;

    int total   = 0;
    int bad     = 0;
    int sw_done = 0;

    wallace_tree_pipe #(
        .WIDTH     (W),
        .NUM_IN    (N),
        .REG_EVERY (1)
    ) u_dut (
        .clock     (clk),
        .reset     (rst_main),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Stage count straight from the row-reduction rule.
    function automatic int ref_stages(input int n, input int re);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            l++;
        end
        return (l + re - 1) / re + 1;
    endfunction

    function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] d);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc + d[k*W +: W];
        end
        return acc;
    endfunction

    function automatic logic [N*W-1:0] rand_set();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) begin
            d[k*W +: W] = W'($urandom);
        end
        return d;
    endfunction

    task automatic shot(input logic [N*W-1:0] d, output int lat, output logic [W-1:0] res);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        lat = 99;
        res = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            #1;
            if (out_valid) begin
                lat = k;
                res = out_data;
                break;
            end
        end
    endtask

    typedef struct {
        logic [N*W-1:0] data;
        logic [W-1:0]   exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int             lat;
        logic [W-1:0]   res;
        logic [W-1:0]   sb [$];
        logic [W-1:0]   held_data;
        logic [N*W-1:0] d;
        logic           held;
        int             sent;
        int             got;
        int             cyc;
        int             seen;

        vecs[0] = '{data: {5{16'h0001}}, exp: 16'h0005};
        vecs[1] = '{data: {5{16'hFFFF}}, exp: 16'hFFFB};
        vecs[2] = '{data: {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, exp: 16'h000F};
        vecs[3] = '{data: {5{16'h0000}}, exp: 16'h0000};
        vecs[4] = '{data: {5{16'h8000}}, exp: 16'h8000};
        vecs[5] = '{data: {16'hAAAA, 16'h0001, 16'h0F0F, 16'h1111, 16'h1234}, exp: 16'hDCFF};

        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_main = 1'b0;
        rst_sw   = 1'b0;

        for (int i = 0; i < 6; i++) begin
            shot(vecs[i].data, lat, res);
            check($sformatf("vec%0d_sum", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(ref_stages(N, 1)));
        end

        // Random stream with random backpressure against an in-order scoreboard.
        sent = 0; got = 0; cyc = 0; held = 1'b0; held_data = '0;
        while (got < 10 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < 10) && ($urandom_range(0, 3) != 0);
            d = rand_set();
            in_data = d;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_data", 64'(out_data), 64'(held_data));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("bp_unexpected_output", 64'(out_data), 64'hDEAD);
                end else begin
                    check($sformatf("bp_result%0d", got), 64'(out_data), 64'(sb.pop_front()));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_sum(d));
                sent++;
            end
            held = out_valid && !out_ready;
            held_data = out_data;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_received", 64'(got), 64'd10);
        check("bp_left_over", 64'(sb.size()), 64'd0);
        repeat (6) @(negedge clk);

        // Three sets back to back, flush with the third one presented.
        in_valid = 1'b1; in_data = vecs[0].data;
        @(negedge clk);
        in_data = vecs[1].data;
        @(negedge clk);
        in_data = vecs[2].data;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("flush_outputs", 64'(seen), 64'd0);

        // Park a result at the output, then reset asynchronously.
        in_valid = 1'b1; in_data = vecs[2].data; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) break;
            @(negedge clk);
        end
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        check("rst_pre_data", 64'(out_data), 64'h000F);
        @(negedge clk);
        in_valid = 1'b1; in_data = vecs[0].data;
        #1;
        rst_main = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_main = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        shot(vecs[5].data, lat, res);
        check("post_rst_sum", 64'(res), 64'h0000_0000_0000_DCFF);
        check("post_rst_latency", 64'(lat), 64'(ref_stages(N, 1)));

        for (int i = 0; i < 3000 && sw_done < 10; i++) @(negedge clk);
        check("sweep_done", 64'(sw_done), 64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    for (genvar w = 0; w < 2; w++) begin : g_w
        for (genvar c = 0; c < 5; c++) begin : g_sw
            localparam int SW = (w == 0) ? 8 : 32;
            localparam int SN = (c == 0) ? 2 : (c == 1) ? 3 : (c == 4) ? 9 : 8;
            localparam int SR = (c == 3) ? 2 : (c == 4) ? 3 : 1;

            logic             s_iv;
            logic             s_ir;
            logic             s_ov;
            logic             s_or;
            logic [SN*SW-1:0] s_id;
            logic [SW-1:0]    s_od;

            wallace_tree_pipe #(
                .WIDTH     (SW),
                .NUM_IN    (SN),
                .REG_EVERY (SR)
            ) u_sw (
                .clock     (clk),
                .reset     (rst_sw),
                .flush     (1'b0),
                .in_valid  (s_iv),
                .in_ready  (s_ir),
                .in_data   (s_id),
                .out_valid (s_ov),
                .out_ready (s_or),
                .out_data  (s_od)
            );

            initial begin
                logic [SN*SW-1:0] d;
                logic [SW-1:0]    e;
                logic [SW-1:0]    res;
                logic [SW-1:0]    op;
                int               lat;
                s_iv = 1'b0;
                s_or = 1'b1;
                s_id = '0;
                wait (rst_sw == 1'b0);
                for (int t = 0; t < 5; t++) begin
                    d = '0;
                    e = '0;
                    for (int i = 0; i < SN; i++) begin
                        op = (t == 0) ? {SW{1'b1}} : SW'({$urandom, $urandom});
                        d[i*SW +: SW] = op;
                        e = e + op;
                    end
                    @(negedge clk);
                    s_iv = 1'b1;
                    s_id = d;
                    #1;
                    check($sformatf("sw_w%0d_n%0d_r%0d_ready", SW, SN, SR), 64'(s_ir), 64'd1);
                    lat = 99;
                    res = '0;
                    for (int k = 1; k <= 20; k++) begin
                        @(negedge clk);
                        if (k == 1) s_iv = 1'b0;
                        #1;
                        if (s_ov) begin
                            lat = k;
                            res = s_od;
                            break;
                        end
                    end
                    check($sformatf("sw_w%0d_n%0d_r%0d_sum", SW, SN, SR), 64'(res), 64'(e));
                    check($sformatf("sw_w%0d_n%0d_r%0d_latency", SW, SN, SR), 64'(lat),
                          64'(ref_stages(SN, SR)));
                end
                sw_done++;
            end
        end
    end

endmodule
